readout_integrator: RTL and testbench

Receive-side counterpart of the pulse engine: consumes the {Q,I} AXI-Stream coming back from the readout ADC, opens an acquisition window at a scheduled timestamp, and integrates a programmed number of samples. It produces signed I/Q sums and a thresholded qubit-state bit. It sits between the ADC stream and the scheduler/CPU result path, sharing the global time counter with the pulse engine.

---
 rtl/readout_integrator.sv | 153 +++++++++++++++
 tb/tb_readout_integrator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/readout_integrator.sv
// Readout integrator: waits for a scheduled timestamp, integrates a programmed number of
// signed {Q,I} ADC samples with saturation, and returns I/Q sums plus a thresholded state bit.
module readout_integrator #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 16,
  parameter int TS_W  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acq_valid,
  output logic             acq_ready,
  input  logic [TS_W-1:0]  acq_t_start,
  input  logic [LEN_W-1:0] acq_t_len,
  input  logic [ACC_W-1:0] acq_threshold,
  input  logic [31:0]      time_counter,
  input  logic [31:0]      s_axis_data,
  input  logic             s_axis_valid,
  output logic             s_axis_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_i,
  output logic [ACC_W-1:0] res_q,
  output logic             res_state,
  output logic             res_sat,
  output logic             res_gap,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WAIT, ACQ, DONE} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state, state_n;
  logic [TS_W-1:0]  t_start;
  logic [LEN_W-1:0] t_len;
  logic [ACC_W-1:0] threshold;
  logic [ACC_W-1:0] acc_i, acc_q;
  logic [LEN_W-1:0] count;
  logic             sat, gap;

  logic [ACC_W-1:0] sext_i, sext_q, sum_i, sum_q;
  logic             clamp_i, clamp_q;
  logic [LEN_W-1:0] count_inc;
  logic             beat, last_beat;

  // Returns {clamped, value}; the extra sum bit exposes overflow in either direction.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) sat_add = {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
    else                        sat_add = {1'b0, s[ACC_W-1:0]};
  endfunction

  assign sext_i    = {{(ACC_W-16){s_axis_data[15]}}, s_axis_data[15:0]};
  assign sext_q    = {{(ACC_W-16){s_axis_data[31]}}, s_axis_data[31:16]};
  assign count_inc = count + LEN_W'(1);

  // NOTE: every signal written here gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_n            = state;
    beat               = 1'b0;
    last_beat          = 1'b0;
    {clamp_i, sum_i}   = sat_add(acc_i, sext_i);
    {clamp_q, sum_q}   = sat_add(acc_q, sext_q);
    case (state)
      IDLE: if (acq_valid) state_n = (acq_t_len == '0) ? DONE : WAIT;
      WAIT: if (time_counter[TS_W-1:0] == t_start) state_n = ACQ;
      ACQ: if (s_axis_valid) begin
        beat = 1'b1;
        if (count_inc == t_len) begin
          last_beat = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The ADC is never stalled; ready only drops while reset is asserted.
  assign acq_ready    = (state == IDLE) && !rst;
  assign s_axis_ready = !rst;
  assign res_valid    = (state == DONE);
  assign busy         = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values. The datapath registers are reset too because the result outputs
  // must read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      t_start   <= '0;
      t_len     <= '0;
      threshold <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      count     <= '0;
      sat       <= 1'b0;
      gap       <= 1'b0;
      res_i     <= '0;
      res_q     <= '0;
      res_state <= 1'b0;
      res_sat   <= 1'b0;
      res_gap   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (acq_valid) begin
          t_start   <= acq_t_start;
          t_len     <= acq_t_len;
          threshold <= acq_threshold;
          acc_i     <= '0;
          acc_q     <= '0;
          count     <= '0;
          sat       <= 1'b0;
          gap       <= 1'b0;
          if (acq_t_len == '0) begin
            res_i     <= '0;
            res_q     <= '0;
            res_state <= $signed({ACC_W{1'b0}}) > $signed(acq_threshold);
            res_sat   <= 1'b0;
            res_gap   <= 1'b0;
          end
        end
        ACQ: if (beat) begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          count <= count_inc;
          sat   <= sat | clamp_i | clamp_q;
          // Results are captured once here so they stay put after the handshake.
          if (last_beat) begin
            res_i     <= sum_i;
            res_q     <= sum_q;
            res_state <= $signed(sum_i) > $signed(threshold);
            res_sat   <= sat | clamp_i | clamp_q;
            res_gap   <= gap;
          end
        end else begin
          gap <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  if (TS_W < 32) begin : g_tc_high
    logic unused_tc_high;
    assign unused_tc_high = ^time_counter[31:TS_W];
  end

endmodule

// File: tb/tb_readout_integrator.sv
// Randomized bench for readout_integrator: a queue-based model replays the driven sample
// stream against the start/length/threshold rules and checks timing, sums and flags.
module tb_readout_integrator;

  localparam int ACC_W = 18;
  localparam int LEN_W = 16;
  localparam int TS_W  = 24;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             acq_valid = 1'b0;
  logic             acq_ready;
  logic [TS_W-1:0]  acq_t_start = '0;
  logic [LEN_W-1:0] acq_t_len = '0;
  logic [ACC_W-1:0] acq_threshold = '0;
  logic [31:0]      time_counter = '0;
  logic [31:0]      s_axis_data = '0;
  logic             s_axis_valid = 1'b0;
  logic             s_axis_ready;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [ACC_W-1:0] res_i, res_q;
  logic             res_state, res_sat, res_gap, busy;

  int n_checks = 0;
  int n_pass   = 0;

  readout_integrator #(.ACC_W(ACC_W), .LEN_W(LEN_W), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst),
    .acq_valid(acq_valid), .acq_ready(acq_ready), .acq_t_start(acq_t_start),
    .acq_t_len(acq_t_len), .acq_threshold(acq_threshold), .time_counter(time_counter),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_i(res_i), .res_q(res_q),
    .res_state(res_state), .res_sat(res_sat), .res_gap(res_gap), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock cycle; the global time advances with it.
  task automatic tick();
    @(posedge clk);
    #1;
    time_counter = time_counter + 1;
  endtask

  // data_mode: 0 fixed, 1 full-range random, 2 small random. valid_mode: 0 always,
  // 1 alternating starting with the first ACQ cycle, 2 random.
  task automatic drive_sample(input int data_mode, input int fi, input int fq,
                              input int valid_mode, input longint t_start);
    logic [15:0] di, dq;
    longint tc;
    tc = longint'(time_counter);
    case (valid_mode)
      0:       s_axis_valid = 1'b1;
      1:       s_axis_valid = (tc > t_start) ? (((tc - t_start - 1) % 2) == 0) : 1'b1;
      default: s_axis_valid = ($urandom_range(0, 3) != 0);
    endcase
    case (data_mode)
      0: begin di = 16'(fi); dq = 16'(fq); end
      1: begin di = 16'($urandom); dq = 16'($urandom); end
      default: begin
        di = 16'(int'($urandom_range(0, 4000)) - 2000);
        dq = 16'(int'($urandom_range(0, 4000)) - 2000);
      end
    endcase
    s_axis_data = {dq, di};
  endtask

  function automatic longint clamp_add(input longint acc, input longint x, inout bit sat);
    longint s;
    s = acc + x;
    if (s > ACC_MAX) begin s = ACC_MAX; sat = 1'b1; end
    if (s < ACC_MIN) begin s = ACC_MIN; sat = 1'b1; end
    return s;
  endfunction

  task automatic run_acq(input longint t_start, input int len, input longint thr,
                         input int data_mode, input int fi, input int fq,
                         input int valid_mode, input int hold);
    longint tcs[$];
    bit     vals[$];
    longint dis[$], dqs[$];
    longint t_acc, exp_done, obs_done, exp_i, exp_q;
    bit     exp_sat, exp_gap;
    int     cnt, budget, cyc;

    check("idle_acq_ready", acq_ready, 1);
    check("idle_busy", busy, 0);
    acq_valid     = 1'b1;
    acq_t_start   = TS_W'(t_start);
    acq_t_len     = LEN_W'(len);
    acq_threshold = ACC_W'(thr);
    drive_sample(1, 0, 0, 2, t_start);
    t_acc = longint'(time_counter);
    tick();
    acq_valid     = 1'b0;
    acq_t_start   = TS_W'($urandom);
    acq_t_len     = LEN_W'($urandom);
    acq_threshold = ACC_W'($urandom);
    check("cmd_busy", busy, 1);

    budget = int'(t_start - t_acc) + 4 * len + 40;
    cyc = 0;
    while (!res_valid && cyc < budget) begin
      drive_sample(data_mode, fi, fq, valid_mode, t_start);
      tcs.push_back(longint'(time_counter));
      vals.push_back(s_axis_valid);
      dis.push_back(longint'($signed(s_axis_data[15:0])));
      dqs.push_back(longint'($signed(s_axis_data[31:16])));
      tick();
      cyc++;
    end
    if (!res_valid) begin
      check("timeout_res_valid", res_valid, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      return;
    end
    obs_done = longint'(time_counter) - 1;

    // Reference: integrate the first len valid beats strictly after the start timestamp.
    exp_i = 0; exp_q = 0; exp_sat = 0; exp_gap = 0; cnt = 0;
    exp_done = (len == 0) ? t_acc : -1;
    for (int k = 0; k < tcs.size(); k++) begin
      if (cnt < len && tcs[k] > t_start) begin
        if (vals[k]) begin
          exp_i = clamp_add(exp_i, dis[k], exp_sat);
          exp_q = clamp_add(exp_q, dqs[k], exp_sat);
          cnt++;
          if (cnt == len) exp_done = tcs[k];
        end else begin
          exp_gap = 1'b1;
        end
      end
    end

    check("done_cycle", obs_done, exp_done);
    check("res_i", longint'($signed(res_i)), exp_i);
    check("res_q", longint'($signed(res_q)), exp_q);
    check("res_state", res_state, longint'(exp_i > thr));
    check("res_sat", res_sat, exp_sat);
    check("res_gap", res_gap, exp_gap);

    acq_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      drive_sample(1, 0, 0, 2, t_start);
      tick();
      check("hold_res_valid", res_valid, 1);
      check("hold_acq_ready", acq_ready, 0);
      check("hold_res_i", longint'($signed(res_i)), exp_i);
      check("hold_res_q", longint'($signed(res_q)), exp_q);
    end
    acq_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("post_hs_res_valid", res_valid, 0);
    check("post_hs_acq_ready", acq_ready, 1);
    check("post_hs_res_i_kept", longint'($signed(res_i)), exp_i);
    check("post_hs_res_state_kept", res_state, longint'(exp_i > thr));
  endtask

  initial begin
    rst = 1'b1;
    #1;
    check("rst_acq_ready", acq_ready, 0);
    check("rst_s_axis_ready", s_axis_ready, 0);
    repeat (3) tick();
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res_i", longint'($signed(res_i)), 0);
    rst = 1'b0;
    #1;
    check("out_of_rst_acq_ready", acq_ready, 1);
    check("out_of_rst_s_axis_ready", s_axis_ready, 1);
    tick();

    // Start at 100, constant I=+1000, Q=-500: sums 4000/-2000, threshold just below.
    run_acq(100, 4, 3999, 0, 1000, -500, 0, 2);
    run_acq(longint'(time_counter) + 5, 4, 4000, 0, 1000, -500, 0, 1);
    // Saturation in both directions.
    run_acq(longint'(time_counter) + 3, 8, 0, 0, 32767, 100, 0, 0);
    run_acq(longint'(time_counter) + 3, 8, 0, 0, -32768, -100, 0, 0);
    // Alternating valid: three beats across five ACQ cycles, gap flagged.
    run_acq(longint'(time_counter) + 4, 3, 0, 0, 7, -9, 1, 0);
    // Zero length with a negative and a non-negative threshold, held for ten cycles.
    run_acq(longint'(time_counter) + 2, 0, -1, 1, 0, 0, 0, 10);
    run_acq(longint'(time_counter) + 2, 0, 0, 1, 0, 0, 0, 3);

    // Reset in the middle of an acquisition discards it entirely.
    acq_valid = 1'b1;
    acq_t_start = TS_W'(time_counter + 2);
    acq_t_len = LEN_W'(50);
    acq_threshold = '0;
    s_axis_valid = 1'b1;
    s_axis_data = {16'sd300, 16'sd500};
    tick();
    acq_valid = 1'b0;
    repeat (8) tick();
    check("mid_acq_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_acq_ready", acq_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("after_rst_busy", busy, 0);
    check("after_rst_res_valid", res_valid, 0);
    check("after_rst_acq_ready", acq_ready, 1);
    check("after_rst_res_i", longint'($signed(res_i)), 0);
    tick();
    run_acq(longint'(time_counter) + 3, 5, 100, 2, 0, 0, 0, 1);

    for (int r = 0; r < 8; r++) begin
      run_acq(longint'(time_counter) + $urandom_range(1, 15), int'($urandom_range(0, 12)),
              longint'($urandom_range(0, 40000)) - 20000, int'($urandom_range(1, 2)), 0, 0,
              ($urandom_range(0, 1) == 0) ? 0 : 2, int'($urandom_range(0, 5)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
